seq_restoring_div: RTL and testbench

//  Multi-cycle unsigned restoring divider: the inverse of the team's 2x2 Vedic multiplier

---
 rtl/seq_restoring_div.sv | 95 +++++++++
 tb/tb_seq_restoring_div.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Produces one quotient bit per clock, MSB first; divide-by-zero completes immediately.
module seq_restoring_div #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CW-1:0]    count;

   // The restored partial remainder is always below the divisor, so its top
   // bit is always zero and only the shifted trial value needs WIDTH+1 bits.
   logic [WIDTH-1:0] p_reg;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   d_ext;
   logic             fits;
   logic [WIDTH-1:0] p_next;
   logic [WIDTH-1:0] q_next;

   always_comb begin
      p_shift = {p_reg, q_reg[WIDTH-1]};
      d_ext   = {1'b0, d_reg};
      fits    = (p_shift >= d_ext);
      p_next  = fits ? WIDTH'(p_shift - d_ext) : p_shift[WIDTH-1:0];
      q_next  = {q_reg[WIDTH-2:0], fits};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         q_reg       <= '0;
         d_reg       <= '0;
         p_reg       <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     done        <= 1'b1;
                  end else begin
                     q_reg <= dividend;
                     d_reg <= divisor;
                     p_reg <= '0;
                     count <= '0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               q_reg <= q_next;
               p_reg <= p_next;
               count <= count + CW'(1);
               // Last iteration: publish the result on the same edge.
               if (count == CW'(WIDTH - 1)) begin
                  quotient    <= q_next;
                  remainder   <= p_next;
                  div_by_zero <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div (WIDTH=4): directed cases plus a
// randomized-gap sweep of all operand pairs against an arithmetic reference.
module tb_seq_restoring_div;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_restoring_div #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Reference model: plain arithmetic, with the divide-by-zero convention.
   function automatic int refQ(input int a, input int b);
      return (b == 0) ? (1 << WIDTH) - 1 : a / b;
   endfunction

   function automatic int refR(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   // Waits (bounded) for done; returns edges seen after the accepting edge.
   task automatic waitDone(output int edges);
      edges = 0;
      while (!done && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic checkResult(input string tag, input int a, input int b, input int edges);
      int qv;
      int rv;
      qv = int'(quotient);
      rv = int'(remainder);
      checkOutput($sformatf("%s done", tag), 32'(done), 32'd1);
      checkOutput($sformatf("%s latency", tag), 32'(edges), (b == 0) ? 32'd0 : 32'(WIDTH));
      checkOutput($sformatf("%s q", tag), 32'(qv), 32'(refQ(a, b)));
      checkOutput($sformatf("%s r", tag), 32'(rv), 32'(refR(a, b)));
      checkOutput($sformatf("%s dz", tag), 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
      if (b != 0) begin
         checkOutput($sformatf("%s inv", tag), 32'(qv * b + rv), 32'(a));
      end
   endtask

   // One complete division; operands are scrambled right after acceptance.
   task automatic applyStimulus(input string tag, input int a, input int b);
      int edges;
      @(negedge clk);
      dividend = WIDTH'(a);
      divisor  = WIDTH'(b);
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);
      checkOutput($sformatf("%s busy", tag), 32'(busy), (b == 0) ? 32'd0 : 32'd1);
      waitDone(edges);
      checkResult(tag, a, b, edges);
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s pulse", tag), 32'(done), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int edges;
      int seen;

      rst = 1'b1;
      #12;
      checkOutput("reset q", 32'(quotient), 32'd0);
      checkOutput("reset r", 32'(remainder), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("13/3", 13, 3);
      applyStimulus("15/1", 15, 1);
      applyStimulus("2/5", 2, 5);
      applyStimulus("15/15", 15, 15);
      applyStimulus("0/7", 0, 7);
      applyStimulus("9/0", 9, 0);
      applyStimulus("8/2", 8, 2);

      // Start while busy is ignored; start during the done cycle is accepted.
      @(negedge clk);
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      dividend = 4'd6;
      divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone(edges);
      checkResult("busy-ignore", 13, 3, edges + 2);
      dividend = 4'd6;
      divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b busy", 32'(busy), 32'd1);
      waitDone(edges);
      checkResult("b2b 6/2", 6, 2, edges);

      // Asynchronous reset mid-operation abandons the division.
      @(negedge clk);
      dividend = 4'd13;
      divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midrst q", 32'(quotient), 32'd0);
      checkOutput("midrst r", 32'(remainder), 32'd0);
      checkOutput("midrst busy", 32'(busy), 32'd0);
      checkOutput("midrst done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      checkOutput("midrst no done", 32'(seen), 32'd0);
      applyStimulus("7/2", 7, 2);

      $display("[TB] exhaustive sweep");
      for (int a = 0; a < (1 << WIDTH); a++) begin
         for (int b = 0; b < (1 << WIDTH); b++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            applyStimulus($sformatf("sweep %0d/%0d", a, b), a, b);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
